// File: rtl/arbitro_ula_pkg.sv
// Shared definitions for the arbitrated add/subtract unit: opcodes, FSM encoding
// and the signed-overflow helper used by the flag logic.
package arbitro_ula_pkg;

    localparam logic OP_SOMA = 1'b0;
    localparam logic OP_SUB  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Signed overflow from operand and result sign bits; subtraction flips the B sign test.
    function automatic logic calc_overflow(
        input logic op_sel,
        input logic sa,
        input logic sb,
        input logic sr
    );
        logic v;
        if (op_sel == OP_SOMA) begin
            v = (sa == sb) && (sr != sa);
        end else begin
            v = (sa != sb) && (sr != sa);
        end
        return v;
    endfunction

endpackage

// File: rtl/arbitro_rr2.sv
// Two-way round-robin selector: a lone request wins outright, a tie goes to the
// requester that was not served last.
module arbitro_rr2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt
);

    // Pick the winning requester id; callers qualify it with |req.
    always_comb begin
        gnt = 1'b0;
        case (req)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
            2'b11:   gnt = ~last_grant;
            default: gnt = 1'b0;
        endcase
    end

endmodule

// File: rtl/arbitro_ula_somasub.sv
// One add/subtract unit shared by two requesters under round-robin arbitration;
// returns registered result, NZCV flags and a one-cycle ack, plus a sticky overflow.
module arbitro_ula_somasub
    import arbitro_ula_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             Req_0,
    input  logic             Sel_0,
    input  logic [WIDTH-1:0] A_0,
    input  logic [WIDTH-1:0] B_0,
    input  logic             Req_1,
    input  logic             Sel_1,
    input  logic [WIDTH-1:0] A_1,
    input  logic [WIDTH-1:0] B_1,
    input  logic             Clear_sticky,
    output logic             Ack_0,
    output logic             Ack_1,
    output logic             Grant_id,
    output logic             Busy,
    output logic [WIDTH-1:0] Result,
    output logic             Negative,
    output logic             Zero,
    output logic             Carry,
    output logic             Overflow,
    output logic             Overflow_sticky
);

    state_t             state_r;
    state_t             state_nx_s;
    logic               last_grant_r;
    logic               gnt_s;
    logic               req_any_s;
    logic               grant_en_s;
    logic               exec_en_s;
    logic               done_en_s;
    logic               sticky_set_s;

    logic               sel_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               sel_in_s;
    logic [WIDTH-1:0]   a_in_s;
    logic [WIDTH-1:0]   b_in_s;
    logic [WIDTH-1:0]   b_op_s;
    logic [WIDTH:0]     sum_s;
    logic               v_s;

    logic               ack0_r;
    logic               ack1_r;
    logic               grant_id_r;
    logic               busy_r;
    logic [WIDTH-1:0]   result_r;
    logic               negative_r;
    logic               zero_r;
    logic               carry_r;
    logic               overflow_r;
    logic               sticky_r;

    assign req_any_s = Req_0 | Req_1;

    arbitro_rr2 u_rr2 (
        .req        ({Req_1, Req_0}),
        .last_grant (last_grant_r),
        .gnt        (gnt_s)
    );

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic: one operation every three cycles.
    always_comb begin
        state_nx_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (req_any_s) begin
                    state_nx_s = ST_EXEC;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_EXEC: state_nx_s = ST_DONE;
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM output decode: per-state enables for the registered datapath.
    always_comb begin
        grant_en_s = 1'b0;
        exec_en_s  = 1'b0;
        done_en_s  = 1'b0;
        case (state_r)
            ST_IDLE: grant_en_s = req_any_s;
            ST_EXEC: exec_en_s  = 1'b1;
            ST_DONE: done_en_s  = 1'b1;
            default: grant_en_s = 1'b0;
        endcase
    end

    // Operand source mux for the requester being granted.
    always_comb begin
        sel_in_s = Sel_0;
        a_in_s   = A_0;
        b_in_s   = B_0;
        if (gnt_s == 1'b1) begin
            sel_in_s = Sel_1;
            a_in_s   = A_1;
            b_in_s   = B_1;
        end else begin
            sel_in_s = Sel_0;
            a_in_s   = A_0;
            b_in_s   = B_0;
        end
    end

    // Subtraction is A + ~B + 1, so carry out means "no borrow".
    assign b_op_s = (sel_r == OP_SUB) ? ~b_r : b_r;
    assign sum_s  = {1'b0, a_r} + {1'b0, b_op_s} + {{WIDTH{1'b0}}, sel_r};
    assign v_s    = calc_overflow(sel_r, a_r[WIDTH-1], b_r[WIDTH-1], sum_s[WIDTH-1]);

    // A DONE cycle carrying V must win over a coincident clear; setting on EXEC too
    // makes the sticky visible alongside the ack.
    assign sticky_set_s = (exec_en_s && v_s) || (done_en_s && overflow_r);

    // Registered datapath, flags, handshake outputs and arbitration history.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_r <= 1'b1;
            sel_r        <= 1'b0;
            a_r          <= {WIDTH{1'b0}};
            b_r          <= {WIDTH{1'b0}};
            ack0_r       <= 1'b0;
            ack1_r       <= 1'b0;
            grant_id_r   <= 1'b0;
            busy_r       <= 1'b0;
            result_r     <= {WIDTH{1'b0}};
            negative_r   <= 1'b0;
            zero_r       <= 1'b0;
            carry_r      <= 1'b0;
            overflow_r   <= 1'b0;
            sticky_r     <= 1'b0;
        end else begin
            ack0_r <= exec_en_s && (grant_id_r == 1'b0);
            ack1_r <= exec_en_s && (grant_id_r == 1'b1);
            busy_r <= grant_en_s || exec_en_s;
            if (grant_en_s) begin
                sel_r      <= sel_in_s;
                a_r        <= a_in_s;
                b_r        <= b_in_s;
                grant_id_r <= gnt_s;
            end
            if (exec_en_s) begin
                result_r   <= sum_s[WIDTH-1:0];
                negative_r <= sum_s[WIDTH-1];
                zero_r     <= (sum_s[WIDTH-1:0] == {WIDTH{1'b0}});
                carry_r    <= sum_s[WIDTH];
                overflow_r <= v_s;
            end
            if (done_en_s) begin
                last_grant_r <= grant_id_r;
            end
            if (sticky_set_s) begin
                sticky_r <= 1'b1;
            end else if (Clear_sticky) begin
                sticky_r <= 1'b0;
            end
        end
    end

    assign Ack_0           = ack0_r;
    assign Ack_1           = ack1_r;
    assign Grant_id        = grant_id_r;
    assign Busy            = busy_r;
    assign Result          = result_r;
    assign Negative        = negative_r;
    assign Zero            = zero_r;
    assign Carry           = carry_r;
    assign Overflow        = overflow_r;
    assign Overflow_sticky = sticky_r;

endmodule

// File: tb/tb_arbitro_ula_somasub.sv
// Directed self-checking bench for arbitro_ula_somasub (WIDTH = 32).
module tb_arbitro_ula_somasub;

    logic        clock;
    logic        reset;
    logic        Req_0, Sel_0, Req_1, Sel_1, Clear_sticky;
    logic [31:0] A_0, B_0, A_1, B_1;
    logic        Ack_0, Ack_1, Grant_id, Busy;
    logic [31:0] Result;
    logic        Negative, Zero, Carry, Overflow, Overflow_sticky;

    int n_cmp;
    int n_err;

    arbitro_ula_somasub #(.WIDTH(32)) dut (
        .clock           (clock),
        .reset           (reset),
        .Req_0           (Req_0),
        .Sel_0           (Sel_0),
        .A_0             (A_0),
        .B_0             (B_0),
        .Req_1           (Req_1),
        .Sel_1           (Sel_1),
        .A_1             (A_1),
        .B_1             (B_1),
        .Clear_sticky    (Clear_sticky),
        .Ack_0           (Ack_0),
        .Ack_1           (Ack_1),
        .Grant_id        (Grant_id),
        .Busy            (Busy),
        .Result          (Result),
        .Negative        (Negative),
        .Zero            (Zero),
        .Carry           (Carry),
        .Overflow        (Overflow),
        .Overflow_sticky (Overflow_sticky)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_cmp++;
        if ({Ack_0, Ack_1, Grant_id, Busy, Negative, Zero, Carry, Overflow, Overflow_sticky} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: got %b expected 000000000",
                     {Ack_0, Ack_1, Grant_id, Busy, Negative, Zero, Carry, Overflow, Overflow_sticky});
        end
        n_cmp++;
        if (Result !== 32'h0) begin
            n_err++;
            $display("FAIL reset_result: got %h expected 00000000", Result);
        end
    endtask

    task automatic test_add_overflow();
        Req_0 = 1'b1; Sel_0 = 1'b0; A_0 = 32'h7FFFFFFF; B_0 = 32'h00000001;
        step();
        n_cmp++;
        if ({Busy, Grant_id, Ack_0, Ack_1} !== 4'b1000) begin
            n_err++;
            $display("FAIL add_exec: got busy/gid/ack0/ack1=%b expected 1000", {Busy, Grant_id, Ack_0, Ack_1});
        end
        step();
        n_cmp++;
        if ({Ack_0, Ack_1} !== 2'b10) begin
            n_err++;
            $display("FAIL add_ack: got %b expected 10", {Ack_0, Ack_1});
        end
        n_cmp++;
        if (Result !== 32'h80000000) begin
            n_err++;
            $display("FAIL add_result: got %h expected 80000000", Result);
        end
        n_cmp++;
        if ({Negative, Zero, Carry, Overflow, Overflow_sticky} !== 5'b10011) begin
            n_err++;
            $display("FAIL add_flags: got NZCVS=%b expected 10011", {Negative, Zero, Carry, Overflow, Overflow_sticky});
        end
        Req_0 = 1'b0;
        step();
        n_cmp++;
        if ({Ack_0, Busy, Overflow_sticky} !== 3'b001 || Result !== 32'h80000000) begin
            n_err++;
            $display("FAIL add_hold: got ack0/busy/sticky=%b result=%h expected 001 80000000",
                     {Ack_0, Busy, Overflow_sticky}, Result);
        end
    endtask

    task automatic test_sub_flags();
        Req_1 = 1'b1; Sel_1 = 1'b1; A_1 = 32'h80000000; B_1 = 32'h00000001;
        step();
        n_cmp++;
        if ({Busy, Grant_id} !== 2'b11) begin
            n_err++;
            $display("FAIL sub_grant: got busy/gid=%b expected 11", {Busy, Grant_id});
        end
        step();
        n_cmp++;
        if ({Ack_0, Ack_1} !== 2'b01 || Result !== 32'h7FFFFFFF) begin
            n_err++;
            $display("FAIL sub_ovf_result: got ack=%b result=%h expected 01 7fffffff", {Ack_0, Ack_1}, Result);
        end
        n_cmp++;
        if ({Negative, Zero, Carry, Overflow} !== 4'b0011) begin
            n_err++;
            $display("FAIL sub_ovf_flags: got NZCV=%b expected 0011", {Negative, Zero, Carry, Overflow});
        end
        Req_1 = 1'b0;
        step();
        Req_1 = 1'b1; A_1 = 32'd5; B_1 = 32'd5;
        step();
        step();
        Req_1 = 1'b0;
        n_cmp++;
        if (Ack_1 !== 1'b1 || Result !== 32'h0) begin
            n_err++;
            $display("FAIL sub_zero_result: got ack1=%b result=%h expected 1 00000000", Ack_1, Result);
        end
        n_cmp++;
        if ({Negative, Zero, Carry, Overflow} !== 4'b0110) begin
            n_err++;
            $display("FAIL sub_zero_flags: got NZCV=%b expected 0110", {Negative, Zero, Carry, Overflow});
        end
        step();
    endtask

    task automatic test_round_robin();
        logic exp_a0, exp_a1, exp_busy, exp_gid;
        logic [31:0] exp_res;
        apply_reset();
        Req_0 = 1'b1; Sel_0 = 1'b0; A_0 = 32'd1;  B_0 = 32'd2;
        Req_1 = 1'b1; Sel_1 = 1'b1; A_1 = 32'd10; B_1 = 32'd3;
        for (int i = 0; i < 12; i++) begin
            step();
            exp_a0   = (i % 6 == 1);
            exp_a1   = (i % 6 == 4);
            exp_busy = (i % 3 != 2);
            exp_gid  = (i % 6 >= 3);
            n_cmp++;
            if ({Ack_0, Ack_1, Busy, Grant_id} !== {exp_a0, exp_a1, exp_busy, exp_gid}) begin
                n_err++;
                $display("FAIL rr_cycle%0d: got ack0/ack1/busy/gid=%b expected %b",
                         i, {Ack_0, Ack_1, Busy, Grant_id}, {exp_a0, exp_a1, exp_busy, exp_gid});
            end
            if (exp_a0 || exp_a1) begin
                exp_res = exp_a0 ? 32'd3 : 32'd7;
                n_cmp++;
                if (Result !== exp_res) begin
                    n_err++;
                    $display("FAIL rr_result%0d: got %h expected %h", i, Result, exp_res);
                end
            end
        end
        Req_0 = 1'b0; Req_1 = 1'b0;
        step();
    endtask

    task automatic test_operand_latch();
        Req_0 = 1'b1; Sel_0 = 1'b0; A_0 = 32'hFFFFFFFF; B_0 = 32'hFFFFFFFF;
        step();
        A_0 = 32'h0; Sel_0 = 1'b1; Req_0 = 1'b0;
        step();
        n_cmp++;
        if (Ack_0 !== 1'b1 || Result !== 32'hFFFFFFFE) begin
            n_err++;
            $display("FAIL latch_result: got ack0=%b result=%h expected 1 fffffffe", Ack_0, Result);
        end
        n_cmp++;
        if ({Negative, Zero, Carry, Overflow} !== 4'b1010) begin
            n_err++;
            $display("FAIL latch_flags: got NZCV=%b expected 1010", {Negative, Zero, Carry, Overflow});
        end
        step();
    endtask

    task automatic test_reset_mid_op();
        Req_1 = 1'b1; Sel_1 = 1'b0; A_1 = 32'd3; B_1 = 32'd4;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++;
        if ({Ack_0, Ack_1, Grant_id, Busy, Negative, Zero, Carry, Overflow, Overflow_sticky} !== 9'b0
            || Result !== 32'h0) begin
            n_err++;
            $display("FAIL midreset_outputs: got ctrl=%b result=%h expected 000000000 00000000",
                     {Ack_0, Ack_1, Grant_id, Busy, Negative, Zero, Carry, Overflow, Overflow_sticky}, Result);
        end
        step();
        n_cmp++;
        if ({Busy, Grant_id, Ack_1} !== 3'b110) begin
            n_err++;
            $display("FAIL midreset_regrant: got busy/gid/ack1=%b expected 110", {Busy, Grant_id, Ack_1});
        end
        step();
        Req_1 = 1'b0;
        n_cmp++;
        if (Ack_1 !== 1'b1 || Result !== 32'd7) begin
            n_err++;
            $display("FAIL midreset_ack: got ack1=%b result=%h expected 1 00000007", Ack_1, Result);
        end
        step();
    endtask

    task automatic test_sticky_clear();
        Req_0 = 1'b1; Sel_0 = 1'b1; A_0 = 32'h80000000; B_0 = 32'h00000001;
        step();
        step();
        Req_0 = 1'b0;
        n_cmp++;
        if ({Ack_0, Overflow} !== 2'b11) begin
            n_err++;
            $display("FAIL sticky_op: got ack0/V=%b expected 11", {Ack_0, Overflow});
        end
        Clear_sticky = 1'b1;
        step();
        Clear_sticky = 1'b0;
        n_cmp++;
        if (Overflow_sticky !== 1'b1) begin
            n_err++;
            $display("FAIL sticky_setwins: got %b expected 1", Overflow_sticky);
        end
        step();
        Clear_sticky = 1'b1;
        step();
        Clear_sticky = 1'b0;
        n_cmp++;
        if (Overflow_sticky !== 1'b0) begin
            n_err++;
            $display("FAIL sticky_clear: got %b expected 0", Overflow_sticky);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        Req_0 = 1'b0; Sel_0 = 1'b0; A_0 = 32'h0; B_0 = 32'h0;
        Req_1 = 1'b0; Sel_1 = 1'b0; A_1 = 32'h0; B_1 = 32'h0;
        Clear_sticky = 1'b0;
        test_reset();
        test_add_overflow();
        test_sub_flags();
        test_round_robin();
        test_operand_latch();
        test_reset_mid_op();
        test_sticky_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
